// File: rtl/pcie_msg_q_pkg.sv
// pcie_msg_q_pkg: shared widths, pointer helpers and saturation constants
// for the multi-queue message interrupt controller.
package pcie_msg_q_pkg;

    localparam int NUM_Q_DEF  = 4;
    localparam int QID_W_DEF  = 2;
    localparam int SLOT_W_DEF = 4;
    localparam int CNT_W_DEF  = 5;
    localparam int TMR_W_DEF  = 16;
    localparam int PTR_MAX_W  = 17;
    localparam logic [7:0] SAT8_MAX = 8'hFF;

    function automatic int ptr_w(input int slot_w);
        return slot_w + 1;
    endfunction

    // Forward distance from b to a on a ring of 2^w entries (w = pointer width).
    function automatic logic [PTR_MAX_W-1:0] ptr_dist(
        input logic [PTR_MAX_W-1:0] a,
        input logic [PTR_MAX_W-1:0] b,
        input int                   w
    );
        logic [PTR_MAX_W-1:0] m;
        m = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
        return (a - b) & m;
    endfunction

endpackage

// File: rtl/pcie_msg_q_chan.sv
// pcie_msg_q_chan: one message ring (wptr/rptr), its read-pointer legality
// check and the coalescing pend/timer/status state for that queue.
module pcie_msg_q_chan
    import pcie_msg_q_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TMR_W  = TMR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_msg,
    input  logic              i_rptr_we,
    input  logic [SLOT_W:0]   i_rptr_wdata,
    input  logic              i_intr_clear,
    input  logic [CNT_W-1:0]  i_coal_thresh,
    input  logic [TMR_W-1:0]  i_coal_timeout,
    output logic [SLOT_W:0]   o_wptr,
    output logic [SLOT_W:0]   o_rptr,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_status,
    output logic              o_rptr_err
);

    localparam int PW = ptr_w(SLOT_W);
    localparam logic [SLOT_W:0]  P_ONE = 1;
    localparam logic [CNT_W-1:0] C_ONE = 1;
    localparam logic [TMR_W-1:0] T_ONE = 1;

    logic [SLOT_W:0]  wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [CNT_W-1:0] pend_q, pend_d, thresh;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             status_q, status_d, accept, rptr_ok, set;

    assign count      = wptr_q - rptr_q;
    assign o_full     = count == {1'b1, {SLOT_W{1'b0}}};
    assign o_empty    = count == '0;
    assign accept     = i_msg && !o_full;
    // Legality uses the pre-accept count so a same-cycle accept cannot widen it.
    assign rptr_ok    = ptr_dist(PTR_MAX_W'(i_rptr_wdata), PTR_MAX_W'(rptr_q), PW) <= PTR_MAX_W'(count);
    assign o_rptr_err = i_rptr_we && !rptr_ok;
    assign thresh     = (i_coal_thresh == '0) ? C_ONE : i_coal_thresh;
    assign set        = !status_q && ((pend_q >= thresh) ||
                        (i_coal_timeout != '0 && tmr_q == i_coal_timeout && pend_q != '0));

    always_comb begin
        wptr_d   = accept ? wptr_q + P_ONE : wptr_q;
        rptr_d   = (i_rptr_we && rptr_ok) ? i_rptr_wdata : rptr_q;
        pend_d   = set ? '0 : (accept && pend_q != '1) ? pend_q + C_ONE : pend_q;
        tmr_d    = set ? '0 : (pend_q != '0 && !status_q) ? tmr_q + T_ONE : tmr_q;
        status_d = set || (status_q && !i_intr_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            pend_q   <= '0;
            tmr_q    <= '0;
            status_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            pend_q   <= pend_d;
            tmr_q    <= tmr_d;
            status_q <= status_d;
        end
    end

    assign o_wptr   = wptr_q;
    assign o_rptr   = rptr_q;
    assign o_status = status_q;

endmodule

// File: rtl/pcie_msg_queue_intr_ctrl.sv
// pcie_msg_queue_intr_ctrl: per-queue message rings with coalesced, maskable
// W1C interrupts plus saturating drop and bad-header counters.
module pcie_msg_queue_intr_ctrl
    import pcie_msg_q_pkg::*;
#(
    parameter int NUM_Q  = NUM_Q_DEF,
    parameter int QID_W  = QID_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TMR_W  = TMR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_msg_done,
    input  logic [QID_W-1:0]          i_msg_qid,
    input  logic                      i_hdr_err,
    input  logic [NUM_Q-1:0]          i_rptr_we,
    input  logic [SLOT_W:0]           i_rptr_wdata,
    input  logic [NUM_Q-1:0]          i_intr_clear,
    input  logic [NUM_Q-1:0]          i_intr_mask,
    input  logic [CNT_W-1:0]          i_coal_thresh,
    input  logic [TMR_W-1:0]          i_coal_timeout,
    output logic [NUM_Q*(SLOT_W+1)-1:0] o_wptr,
    output logic [NUM_Q*(SLOT_W+1)-1:0] o_rptr,
    output logic [NUM_Q-1:0]          o_full,
    output logic [NUM_Q-1:0]          o_empty,
    output logic [NUM_Q-1:0]          o_intr_status,
    output logic                      o_msg_interrupt,
    output logic                      o_msg_drop,
    output logic                      o_rptr_err,
    output logic [7:0]                o_drop_cnt,
    output logic [7:0]                o_bad_hdr_cnt
);

    logic [NUM_Q-1:0] hit, rptr_err;
    logic             drop, intr_q, intr_d, drop_q, rptr_err_q, rptr_err_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d, hdr_cnt_q, hdr_cnt_d;

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        assign hit[g] = i_msg_done && (i_msg_qid == QID_W'(g));
        pcie_msg_q_chan #(
            .SLOT_W (SLOT_W),
            .CNT_W  (CNT_W),
            .TMR_W  (TMR_W)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .i_msg          (hit[g]),
            .i_rptr_we      (i_rptr_we[g]),
            .i_rptr_wdata   (i_rptr_wdata),
            .i_intr_clear   (i_intr_clear[g]),
            .i_coal_thresh  (i_coal_thresh),
            .i_coal_timeout (i_coal_timeout),
            .o_wptr         (o_wptr[g*(SLOT_W+1) +: SLOT_W+1]),
            .o_rptr         (o_rptr[g*(SLOT_W+1) +: SLOT_W+1]),
            .o_full         (o_full[g]),
            .o_empty        (o_empty[g]),
            .o_status       (o_intr_status[g]),
            .o_rptr_err     (rptr_err[g])
        );
    end

    // An out-of-range qid hits no queue, so it falls into the drop case too.
    assign drop = i_msg_done && !(|(hit & ~o_full));

    always_comb begin
        drop_cnt_d = (drop && drop_cnt_q != SAT8_MAX) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        hdr_cnt_d  = (i_hdr_err && hdr_cnt_q != SAT8_MAX) ? hdr_cnt_q + 8'd1 : hdr_cnt_q;
        intr_d     = |(o_intr_status & ~i_intr_mask);
        rptr_err_d = |rptr_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= 1'b0;
            rptr_err_q <= 1'b0;
            intr_q     <= 1'b0;
            drop_cnt_q <= '0;
            hdr_cnt_q  <= '0;
        end else begin
            drop_q     <= drop;
            rptr_err_q <= rptr_err_d;
            intr_q     <= intr_d;
            drop_cnt_q <= drop_cnt_d;
            hdr_cnt_q  <= hdr_cnt_d;
        end
    end

    assign o_msg_drop      = drop_q;
    assign o_rptr_err      = rptr_err_q;
    assign o_msg_interrupt = intr_q;
    assign o_drop_cnt      = drop_cnt_q;
    assign o_bad_hdr_cnt   = hdr_cnt_q;

endmodule

// File: tb/tb_pcie_msg_queue_intr_ctrl.sv
// tb_pcie_msg_queue_intr_ctrl: scenario tasks against a pointer/drop model;
// ring state expectations are queued at stimulus time and popped after the edge.
module tb_pcie_msg_queue_intr_ctrl;

    localparam int NQ = 4;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_msg_done = 1'b0;
    logic [1:0]    i_msg_qid = '0;
    logic          i_hdr_err = 1'b0;
    logic [NQ-1:0] i_rptr_we = '0;
    logic [PW-1:0] i_rptr_wdata = '0;
    logic [NQ-1:0] i_intr_clear = '0;
    logic [NQ-1:0] i_intr_mask = '0;
    logic [4:0]    i_coal_thresh = 5'd1;
    logic [15:0]   i_coal_timeout = '0;
    logic [NQ*PW-1:0] o_wptr, o_rptr;
    logic [NQ-1:0] o_full, o_empty, o_intr_status;
    logic          o_msg_interrupt, o_msg_drop, o_rptr_err;
    logic [7:0]    o_drop_cnt, o_bad_hdr_cnt;

    typedef struct {
        logic [NQ*PW-1:0] wptr;
        logic [NQ*PW-1:0] rptr;
        logic             drop;
        logic             err;
        logic [7:0]       dcnt;
    } exp_t;

    exp_t sb[$];
    int   mw[NQ], mr[NQ], mdrop;
    int   n_vec = 0, n_err = 0;

    pcie_msg_queue_intr_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_msg_done      (i_msg_done),
        .i_msg_qid       (i_msg_qid),
        .i_hdr_err       (i_hdr_err),
        .i_rptr_we       (i_rptr_we),
        .i_rptr_wdata    (i_rptr_wdata),
        .i_intr_clear    (i_intr_clear),
        .i_intr_mask     (i_intr_mask),
        .i_coal_thresh   (i_coal_thresh),
        .i_coal_timeout  (i_coal_timeout),
        .o_wptr          (o_wptr),
        .o_rptr          (o_rptr),
        .o_full          (o_full),
        .o_empty         (o_empty),
        .o_intr_status   (o_intr_status),
        .o_msg_interrupt (o_msg_interrupt),
        .o_msg_drop      (o_msg_drop),
        .o_rptr_err      (o_rptr_err),
        .o_drop_cnt      (o_drop_cnt),
        .o_bad_hdr_cnt   (o_bad_hdr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NQ*PW-1:0] packp(input int p[NQ]);
        logic [NQ*PW-1:0] r;
        for (int i = 0; i < NQ; i++) r[i*PW +: PW] = PW'(p[i]);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic drop, input logic err);
        exp_t e;
        e.wptr = packp(mw);
        e.rptr = packp(mr);
        e.drop = drop;
        e.err  = err;
        e.dcnt = 8'(mdrop);
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (o_wptr !== e.wptr) begin n_err++; $display("FAIL %s wptr: got %h want %h", tag, o_wptr, e.wptr); end
            n_vec++;
            if (o_rptr !== e.rptr) begin n_err++; $display("FAIL %s rptr: got %h want %h", tag, o_rptr, e.rptr); end
            n_vec++;
            if (o_msg_drop !== e.drop) begin n_err++; $display("FAIL %s drop: got %b want %b", tag, o_msg_drop, e.drop); end
            n_vec++;
            if (o_rptr_err !== e.err) begin n_err++; $display("FAIL %s rptr_err: got %b want %b", tag, o_rptr_err, e.err); end
            n_vec++;
            if (o_drop_cnt !== e.dcnt) begin n_err++; $display("FAIL %s drop_cnt: got %0d want %0d", tag, o_drop_cnt, e.dcnt); end
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < NQ; i++) begin mw[i] = 0; mr[i] = 0; end
        mdrop = 0;
    endtask

    task automatic do_reset;
        i_msg_done = 0; i_hdr_err = 0; i_rptr_we = '0;
        i_intr_clear = '0; i_intr_mask = '0;
        rst = 1;
        tick;
        tick;
        rst = 0;
        model_clear();
    endtask

    task automatic model_accept(input int q, output logic acc);
        acc = ((mw[q] - mr[q]) & 31) < 16;
        if (acc) mw[q] = (mw[q] + 1) & 31;
        else if (mdrop < 255) mdrop++;
    endtask

    task automatic send(input int q);
        logic acc;
        model_accept(q, acc);
        push_exp(!acc, 1'b0);
        i_msg_done = 1;
        i_msg_qid  = 2'(q);
        tick;
        i_msg_done = 0;
        check_sb("send");
    endtask

    task automatic wr_rptr(input int q, input int v);
        logic legal;
        legal = ((v - mr[q]) & 31) <= ((mw[q] - mr[q]) & 31);
        if (legal) mr[q] = v;
        push_exp(1'b0, !legal);
        i_rptr_we    = NQ'(1 << q);
        i_rptr_wdata = PW'(v);
        tick;
        i_rptr_we = '0;
        check_sb("rptr");
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++; if (o_wptr !== '0) begin n_err++; $display("FAIL reset wptr: got %h want 0", o_wptr); end
        n_vec++; if (o_rptr !== '0) begin n_err++; $display("FAIL reset rptr: got %h want 0", o_rptr); end
        n_vec++; if (o_empty !== 4'hF) begin n_err++; $display("FAIL reset empty: got %b want 1111", o_empty); end
        n_vec++; if (o_full !== 4'h0) begin n_err++; $display("FAIL reset full: got %b want 0000", o_full); end
        n_vec++; if (o_intr_status !== 4'h0) begin n_err++; $display("FAIL reset status: got %b want 0000", o_intr_status); end
        n_vec++; if (o_msg_interrupt !== 1'b0) begin n_err++; $display("FAIL reset intr: got %b want 0", o_msg_interrupt); end
        n_vec++; if (o_drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset drop_cnt: got %0d want 0", o_drop_cnt); end
        n_vec++; if (o_bad_hdr_cnt !== 8'd0) begin n_err++; $display("FAIL reset hdr_cnt: got %0d want 0", o_bad_hdr_cnt); end
    endtask

    task automatic test_single_msg;
        do_reset();
        i_coal_thresh = 5'd1;
        i_coal_timeout = '0;
        send(2);
        n_vec++; if (o_intr_status !== 4'b0000) begin n_err++; $display("FAIL single status+1: got %b want 0000", o_intr_status); end
        tick;
        n_vec++; if (o_intr_status !== 4'b0100) begin n_err++; $display("FAIL single status+2: got %b want 0100", o_intr_status); end
        n_vec++; if (o_msg_interrupt !== 1'b0) begin n_err++; $display("FAIL single intr+2: got %b want 0", o_msg_interrupt); end
        tick;
        n_vec++; if (o_msg_interrupt !== 1'b1) begin n_err++; $display("FAIL single intr+3: got %b want 1", o_msg_interrupt); end
        i_intr_clear = 4'b0100;
        tick;
        i_intr_clear = '0;
        n_vec++; if (o_intr_status !== 4'b0000) begin n_err++; $display("FAIL single clear: got %b want 0000", o_intr_status); end
        tick;
        n_vec++; if (o_msg_interrupt !== 1'b0) begin n_err++; $display("FAIL single intr after clear: got %b want 0", o_msg_interrupt); end
    endtask

    task automatic test_fill_drop;
        do_reset();
        i_coal_thresh = 5'd31;
        i_coal_timeout = '0;
        for (int i = 0; i < 16; i++) send(0);
        n_vec++; if (o_full[0] !== 1'b1) begin n_err++; $display("FAIL fill full: got %b want 1", o_full[0]); end
        send(0);
        n_vec++; if (o_wptr[4:0] !== 5'h10) begin n_err++; $display("FAIL fill wptr0: got %h want 10", o_wptr[4:0]); end
        n_vec++; if (o_drop_cnt !== 8'd1) begin n_err++; $display("FAIL fill drop_cnt: got %0d want 1", o_drop_cnt); end
        tick;
        n_vec++; if (o_msg_drop !== 1'b0) begin n_err++; $display("FAIL fill drop pulse width: got %b want 0", o_msg_drop); end
    endtask

    task automatic test_wrap;
        wr_rptr(0, 16);
        for (int i = 0; i < 16; i++) send(0);
        n_vec++; if (o_full[0] !== 1'b1) begin n_err++; $display("FAIL wrap full: got %b want 1", o_full[0]); end
        wr_rptr(0, 0);
        n_vec++; if (o_empty[0] !== 1'b1) begin n_err++; $display("FAIL wrap empty: got %b want 1", o_empty[0]); end
        for (int i = 0; i < 4; i++) send(0);
        n_vec++; if (o_wptr[4:0] !== 5'h04) begin n_err++; $display("FAIL wrap wptr0: got %h want 04", o_wptr[4:0]); end
        n_vec++; if (5'(o_wptr[4:0] - o_rptr[4:0]) !== 5'd4) begin n_err++; $display("FAIL wrap count: got %0d want 4", 5'(o_wptr[4:0] - o_rptr[4:0])); end
        wr_rptr(0, 10);
        n_vec++; if (o_rptr[4:0] !== 5'h00) begin n_err++; $display("FAIL wrap illegal rptr: got %h want 00", o_rptr[4:0]); end
    endtask

    task automatic test_coalesce;
        do_reset();
        i_coal_thresh = 5'd3;
        i_coal_timeout = 16'd50;
        send(1);
        send(1);
        repeat (49) tick;
        n_vec++; if (o_intr_status[1] !== 1'b0) begin n_err++; $display("FAIL coal timer early: got %b want 0", o_intr_status[1]); end
        tick;
        n_vec++; if (o_intr_status[1] !== 1'b1) begin n_err++; $display("FAIL coal timer fire: got %b want 1", o_intr_status[1]); end
        i_intr_clear = 4'b0010;
        tick;
        i_intr_clear = '0;
        n_vec++; if (o_intr_status[1] !== 1'b0) begin n_err++; $display("FAIL coal clear: got %b want 0", o_intr_status[1]); end
        send(1);
        send(1);
        send(1);
        n_vec++; if (o_intr_status[1] !== 1'b0) begin n_err++; $display("FAIL coal thresh early: got %b want 0", o_intr_status[1]); end
        tick;
        n_vec++; if (o_intr_status[1] !== 1'b1) begin n_err++; $display("FAIL coal thresh fire: got %b want 1", o_intr_status[1]); end
    endtask

    task automatic test_collision_mask;
        logic acc, legal;
        do_reset();
        i_coal_thresh = 5'd0;
        i_coal_timeout = '0;
        send(3);
        i_intr_clear = 4'b1000;
        tick;
        i_intr_clear = '0;
        n_vec++; if (o_intr_status !== 4'b1000) begin n_err++; $display("FAIL collide set-vs-clear: got %b want 1000", o_intr_status); end
        i_intr_mask = 4'b1000;
        tick;
        n_vec++; if (o_msg_interrupt !== 1'b0) begin n_err++; $display("FAIL mask intr: got %b want 0", o_msg_interrupt); end
        n_vec++; if (o_intr_status[3] !== 1'b1) begin n_err++; $display("FAIL mask status: got %b want 1", o_intr_status[3]); end
        i_intr_mask = '0;
        tick;
        n_vec++; if (o_msg_interrupt !== 1'b1) begin n_err++; $display("FAIL unmask intr: got %b want 1", o_msg_interrupt); end
        for (int k = 0; k < 2; k++) begin
            legal = ((2*k + 1 - mr[3]) & 31) <= ((mw[3] - mr[3]) & 31);
            if (legal) mr[3] = 2*k + 1;
            model_accept(3, acc);
            push_exp(!acc, !legal);
            i_msg_done = 1; i_msg_qid = 2'd3;
            i_rptr_we = 4'b1000; i_rptr_wdata = PW'(2*k + 1);
            tick;
            i_msg_done = 0; i_rptr_we = '0;
            check_sb("same-cycle");
        end
        n_vec++; if (o_rptr[19:15] !== 5'd1) begin n_err++; $display("FAIL same-cycle rptr3: got %0d want 1", o_rptr[19:15]); end
    endtask

    task automatic test_counters_reset;
        do_reset();
        i_coal_thresh = 5'd1;
        i_hdr_err = 1;
        for (int i = 0; i < 10; i++) send(0);
        i_hdr_err = 0;
        n_vec++; if (o_bad_hdr_cnt !== 8'd10) begin n_err++; $display("FAIL hdr_cnt 10: got %0d want 10", o_bad_hdr_cnt); end
        i_hdr_err = 1;
        repeat (290) tick;
        i_hdr_err = 0;
        n_vec++; if (o_bad_hdr_cnt !== 8'd255) begin n_err++; $display("FAIL hdr_cnt sat: got %0d want 255", o_bad_hdr_cnt); end
        i_msg_done = 1; i_msg_qid = 2'd0; i_hdr_err = 1;
        repeat (3) tick;
        #2 rst = 1;
        #1;
        n_vec++; if (o_wptr !== '0) begin n_err++; $display("FAIL midreset wptr: got %h want 0", o_wptr); end
        n_vec++; if (o_empty !== 4'hF) begin n_err++; $display("FAIL midreset empty: got %b want 1111", o_empty); end
        n_vec++; if (o_intr_status !== 4'h0) begin n_err++; $display("FAIL midreset status: got %b want 0000", o_intr_status); end
        n_vec++; if (o_msg_interrupt !== 1'b0) begin n_err++; $display("FAIL midreset intr: got %b want 0", o_msg_interrupt); end
        n_vec++; if (o_bad_hdr_cnt !== 8'd0) begin n_err++; $display("FAIL midreset hdr_cnt: got %0d want 0", o_bad_hdr_cnt); end
        i_msg_done = 0; i_hdr_err = 0;
        @(posedge clk);
        #1 rst = 0;
        model_clear();
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_fill_drop();
        test_wrap();
        test_coalesce();
        test_collision_mask();
        test_counters_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
